mem_arbiter: RTL

Two-requester arbiter that shares the single-port 64-bit word memory between the SKI reduction engine (requester 0) and the heap allocator/GC (requester 1). Issues at most one access per cycle to the memory. Tracks in-flight reads through the memory's fixed read pipeline and steers each returning word back to the requester that issued it. Sits directly in front of the memory instance.

---
 rtl/mem_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port word memory.
// Optional MEM_ARB_LOCK_EN adds lock0/lock1 for atomic read-modify-write.
module mem_arbiter #(
  parameter int AW     = 30,
  parameter int DW     = 64,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
`ifdef MEM_ARB_LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic              r_last;
  logic [RD_LAT-1:0] r_pv;
  logic [RD_LAT-1:0] r_pid;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_any;
  logic              w_we;

`ifdef MEM_ARB_LOCK_EN
  logic r_locked;
  logic r_lock_id;
  logic w_glock;
`endif

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
`ifdef MEM_ARB_LOCK_EN
      if (r_locked) begin
        w_gnt0 = req0 & !r_lock_id;
        w_gnt1 = req1 & r_lock_id;
      end else begin
        w_gnt1 = req1 & (!req0 | !r_last);
        w_gnt0 = req0 & !w_gnt1;
      end
`else
      // r_last holds the previous grantee; the other side wins a conflict
      w_gnt1 = req1 & (!req0 | !r_last);
      w_gnt0 = req0 & !w_gnt1;
`endif
    end
  end

  assign w_any     = w_gnt0 | w_gnt1;
  assign w_we      = w_gnt1 ? we1 : we0;
  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign mem_addr  = w_gnt1 ? addr1 : addr0;
  assign mem_wdata = w_gnt1 ? wdata1 : wdata0;
  assign mem_wen   = w_any & w_we;

`ifdef MEM_ARB_LOCK_EN
  assign w_glock = w_gnt1 ? lock1 : lock0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
      r_pv   <= '0;
      r_pid  <= '0;
`ifdef MEM_ARB_LOCK_EN
      r_locked  <= 1'b0;
      r_lock_id <= 1'b0;
`endif
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_pv[i]  <= r_pv[i-1];
        r_pid[i] <= r_pid[i-1];
      end
      r_pv[0]  <= w_any & !w_we;
      r_pid[0] <= w_gnt1;
      if (w_any) begin
        r_last <= w_gnt1;
`ifdef MEM_ARB_LOCK_EN
        // only the holder can be granted while locked, so this also unlocks
        r_locked  <= w_glock;
        r_lock_id <= w_gnt1;
`endif
      end
    end
  end

  assign rvalid0 = !reset & r_pv[RD_LAT-1] & !r_pid[RD_LAT-1];
  assign rvalid1 = !reset & r_pv[RD_LAT-1] & r_pid[RD_LAT-1];
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

endmodule
